// File: rtl/pipeline_if_stage_pkg.sv
// Shared definitions for the pipeline_cpu front end: datapath width, the NOP
// encoding, the IF/ID register layout (also consumed by the ID stage) and the
// per-edge update selector used by the fetch stage.
package pipeline_pkg;

    localparam int XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0
    localparam int PC_INC = 4;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    // What the fetch stage does at the next edge when not in reset
    typedef enum logic [1:0] {
        UPD_NORMAL   = 2'd0,
        UPD_STALL    = 2'd1,
        UPD_REDIRECT = 2'd2
    } upd_sel_t;

    // Instruction fetches are always word aligned
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipeline_if_stage_if.sv
// Bus between the fetch stage and its neighbours: instruction memory port,
// hazard/branch control inputs and the IF/ID register outputs.
// master = fetch stage, slave = surrounding core / memory.
interface pipeline_if_stage_if
    import pipeline_pkg::*;
#(
    parameter int XLEN = pipeline_pkg::XLEN
);
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            stall;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] if_id_pc;
    logic [31:0]     if_id_instr;
    logic            if_id_valid;

    modport master (
        output imem_addr, if_id_pc, if_id_instr, if_id_valid,
        input  imem_rdata, stall, redirect_en, redirect_pc
    );

    modport slave (
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid,
        output imem_rdata, stall, redirect_en, redirect_pc
    );
endinterface

// File: rtl/pipeline_if_stage_perf_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module if_perf_counter #(
    parameter int CNT_W = 32
)(
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    // Count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage of the 5-stage RV64I pipeline: owns the PC, drives
// the instruction-memory address and captures the fetched word into IF/ID.
// Per-edge priority: reset > redirect > stall > normal fetch.
// Optional performance counters are built when IF_PERF_CNT_EN is defined;
// otherwise the cnt_* outputs read as zero.
module pipeline_if_stage
    import pipeline_pkg::*;
#(
    parameter int              XLEN     = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
)(
    input  logic                clk,
    input  logic                reset_b,
    pipeline_if_stage_if.master bus,
    output logic                fetch_misalign,
    output logic [CNT_W-1:0]    cnt_fetch,
    output logic [CNT_W-1:0]    cnt_stall,
    output logic [CNT_W-1:0]    cnt_flush
);
    logic [XLEN-1:0] pc_reg,       pc_next;
    if_id_t          if_id_reg,    if_id_next;
    logic            misalign_reg, misalign_next;
    upd_sel_t        upd_sel;

    // A redirect overrides a simultaneous stall: the stalled fetch is wrong-path
    always_comb begin
        upd_sel = UPD_NORMAL;
        if (bus.redirect_en) begin
            upd_sel = UPD_REDIRECT;
        end else if (bus.stall) begin
            upd_sel = UPD_STALL;
        end
    end

    // Next PC, IF/ID contents and sticky misalign flag for each update kind
    always_comb begin
        pc_next       = pc_reg;
        if_id_next    = if_id_reg;
        misalign_next = misalign_reg;
        case (upd_sel)
            UPD_REDIRECT: begin
                pc_next          = align_pc(bus.redirect_pc);
                if_id_next.pc    = '0;
                if_id_next.instr = NOP_INSTR;
                if_id_next.valid = 1'b0;
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    misalign_next = 1'b1;
                end
            end
            UPD_STALL: begin
                // hold everything
            end
            default: begin
                // PC wraps modulo 2^XLEN; no overflow indication
                pc_next          = pc_reg + XLEN'(PC_INC);
                if_id_next.pc    = pc_reg;
                if_id_next.instr = bus.imem_rdata;
                if_id_next.valid = 1'b1;
            end
        endcase
    end

    // Stage state; reset discards any in-flight fetch at that edge
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            pc_reg          <= RESET_PC;
            if_id_reg.pc    <= '0;
            if_id_reg.instr <= NOP_INSTR;
            if_id_reg.valid <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            if_id_reg    <= if_id_next;
            misalign_reg <= misalign_next;
        end
    end

    // Memory address depends on the PC register only
    assign bus.imem_addr   = pc_reg;
    assign bus.if_id_pc    = if_id_reg.pc;
    assign bus.if_id_instr = if_id_reg.instr;
    assign bus.if_id_valid = if_id_reg.valid;
    assign fetch_misalign  = misalign_reg;

`ifdef IF_PERF_CNT_EN
    // Event index: 0 = fetch capture, 1 = stall-only cycle, 2 = redirect cycle
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    assign cnt_inc[0] = (upd_sel == UPD_NORMAL);
    assign cnt_inc[1] = (upd_sel == UPD_STALL);
    assign cnt_inc[2] = (upd_sel == UPD_REDIRECT);

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_cnt
        if_perf_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .clr   (!reset_b),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
        );
    end

    assign cnt_fetch = cnt_val[0];
    assign cnt_stall = cnt_val[1];
    assign cnt_flush = cnt_val[2];
`else
    assign cnt_fetch = '0;
    assign cnt_stall = '0;
    assign cnt_flush = '0;
`endif

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Scoreboard bench for pipeline_if_stage: a driver applies directed then
// random stimulus and pushes the expected post-edge state into a queue; a
// monitor pops one entry per clock and compares it with the DUT outputs.
// Counter expectations follow IF_PERF_CNT_EN (zero when undefined).
module tb_pipeline_if_stage;
    import pipeline_pkg::*;

    localparam int          CW  = 4;      // small so saturation is reached
    localparam logic [63:0] RPC = 64'h0;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_b;
    logic          fetch_misalign;
    logic [CW-1:0] cnt_fetch, cnt_stall, cnt_flush;

    pipeline_if_stage_if #(.XLEN(64)) bus ();

    // Instruction memory contents: a distinct word per word address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[17:2], ~a[17:2]} ^ 32'h5a5a_3c3c ^ a[49:18];
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    pipeline_if_stage #(
        .XLEN     (64),
        .RESET_PC (RPC),
        .CNT_W    (CW)
    ) dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .bus            (bus),
        .fetch_misalign (fetch_misalign),
        .cnt_fetch      (cnt_fetch),
        .cnt_stall      (cnt_stall),
        .cnt_flush      (cnt_flush)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
        int          cf, cs, cl;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (architectural view)
    bit          known = 1'b0;
    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_mis;
    int          m_cf, m_cs, m_cl;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // One clock of stimulus; model the edge and queue the expected outcome
    task automatic step(input bit rb, input bit st, input bit rd, input logic [63:0] rp);
        exp_t e;
        reset_b         = rb;
        bus.stall       = st;
        bus.redirect_en = rd;
        bus.redirect_pc = rp;
        if (!rb) begin
            known   = 1'b1;
            m_pc    = RPC;
            m_ipc   = 64'h0;
            m_instr = NOP_INSTR;
            m_valid = 1'b0;
            m_mis   = 1'b0;
            m_cf = 0; m_cs = 0; m_cl = 0;
        end else if (known) begin
            if (rd) begin
                m_pc    = rp & ~64'h3;
                m_ipc   = 64'h0;
                m_instr = NOP_INSTR;
                m_valid = 1'b0;
                if (rp[1:0] != 2'b00) m_mis = 1'b1;
                m_cl = sat_inc(m_cl);
            end else if (st) begin
                m_cs = sat_inc(m_cs);
            end else begin
                m_ipc   = m_pc;
                m_instr = mem_word(m_pc);
                m_valid = 1'b1;
                m_pc    = m_pc + 64'd4;
                m_cf = sat_inc(m_cf);
            end
        end
        if (known) begin
            e.addr = m_pc; e.ipc = m_ipc; e.instr = m_instr;
            e.valid = m_valid; e.mis = m_mis;
`ifdef IF_PERF_CNT_EN
            e.cf = m_cf; e.cs = m_cs; e.cl = m_cl;
`else
            e.cf = 0; e.cs = 0; e.cl = 0;
`endif
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: after each edge, compare the DUT against the oldest expectation
    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr",   bus.imem_addr,             e.addr);
                chk("if_id_pc",    bus.if_id_pc,              e.ipc);
                chk("if_id_instr", {32'h0, bus.if_id_instr},  {32'h0, e.instr});
                chk("if_id_valid", {63'h0, bus.if_id_valid},  {63'h0, e.valid});
                chk("misalign",    {63'h0, fetch_misalign},   {63'h0, e.mis});
                chk("cnt_fetch",   64'(cnt_fetch),            64'(e.cf));
                chk("cnt_stall",   64'(cnt_stall),            64'(e.cs));
                chk("cnt_flush",   64'(cnt_flush),            64'(e.cl));
                $display("cyc %0d addr=%h if_id_pc=%h instr=%h v=%b mis=%b cnt=%0d/%0d/%0d",
                         cyc, bus.imem_addr, bus.if_id_pc, bus.if_id_instr,
                         bus.if_id_valid, fetch_misalign, cnt_fetch, cnt_stall, cnt_flush);
            end
        end
    endtask

    initial begin
        logic [63:0] rp;
        int          drain;
        reset_b         = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 64'h0;
        #2;
        fork
            monitor();
        join_none

        // Reset, then straight-line fetch 0,4,8
        step(0, 0, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        repeat (2) step(1, 0, 0, 64'h0);
        // Stall two cycles at pc 8, then resume
        repeat (2) step(1, 1, 0, 64'h0);
        repeat (2) step(1, 0, 0, 64'h0);
        // Redirect while stalled
        step(1, 1, 1, 64'h40);
        repeat (2) step(1, 0, 0, 64'h0);
        // Misaligned target, flag must stick
        step(1, 0, 1, 64'h46);
        repeat (3) step(1, 0, 0, 64'h0);
        // PC wrap at the top of the address space
        step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (3) step(1, 0, 0, 64'h0);
        // Back-to-back redirects
        step(1, 0, 1, 64'h100);
        step(1, 1, 1, 64'h203);
        step(1, 0, 0, 64'h0);
        // Mid-stream reset
        repeat (4) step(1, 0, 0, 64'h0);
        step(0, 1, 1, 64'h80);
        repeat (20) step(1, 0, 0, 64'h0);   // drives cnt_fetch into saturation

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rp = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            step(($urandom_range(0, 79) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 rp);
        end

        // Let the monitor consume anything still queued, within a bound
        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(posedge clk);
            #2;
            drain++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_if_stage.md
Name: pipeline_if_stage

Overview:
Instruction-fetch stage of the 5-stage RV64I pipeline_cpu, sitting directly upstream of the ID stage and register-file read. It holds the PC, drives the instruction-memory address and captures the fetched word into the IF/ID pipeline register. It honours stall requests from hazard detection and redirect/flush requests from branch resolution.

Parameters:
XLEN, 64, datapath/PC width in bits.
RESET_PC, 64'h0, PC value loaded on reset.
CNT_W, 32, width of each performance counter (used only with IF_PERF_CNT_EN).

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset_b  input  1  synchronous, active-low reset.
imem_addr  output  XLEN  instruction-memory byte address; combinationally equals pc_q.
imem_rdata  input  32  instruction word at imem_addr; combinational read, valid in the same cycle.
stall  input  1  hold PC and IF/ID register (load-use hazard).
redirect_en  input  1  taken branch/jump resolved; flush IF/ID and load redirect_pc.
redirect_pc  input  XLEN  branch/jump target.
if_id_pc  output  XLEN  PC of the instruction in IF/ID.
if_id_instr  output  32  instruction in IF/ID.
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
fetch_misalign  output  1  sticky flag: a redirect target with bits[1:0] != 0 was received.
cnt_fetch  output  CNT_W  instructions captured into IF/ID.
cnt_stall  output  CNT_W  cycles with stall=1 and no redirect.
cnt_flush  output  CNT_W  cycles with redirect_en=1.

Behaviour:
- Reset: on a rising edge with reset_b=0, pc_q <= RESET_PC, if_id_pc <= 0, if_id_instr <= NOP (32'h00000013), if_id_valid <= 0, fetch_misalign <= 0, all counters <= 0. Reset asserted mid-operation discards in-flight state at that edge.
- Update priority per edge: reset > redirect > stall > normal.
- Normal (stall=0, redirect_en=0): pc_q <= pc_q + 4. IF/ID <= {pc_q, imem_rdata, valid=1}. Latency is 1 cycle from imem_addr presentation to IF/ID visibility.
- Stall (stall=1, redirect_en=0): pc_q and all IF/ID fields hold their values.
- Redirect (redirect_en=1, regardless of stall):
  - pc_q <= {redirect_pc[XLEN-1:2], 2'b00}.
  - IF/ID <= {pc=0, instr=NOP, valid=0}, which squashes the wrong-path fetch.
  - If redirect_pc[1:0] != 0, fetch_misalign <= 1; it stays set until reset.
- The first fetch after reset releases is captured at the next edge. Back-to-back redirects each take effect at their own edge.
- PC arithmetic is modulo 2^XLEN: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 with no flag.
- imem_addr is combinational from pc_q only, with no path from stall or redirect inputs.
- All outputs except imem_addr are registered.

Optional Feature:
IF_PERF_CNT_EN:
- Defined: cnt_fetch increments on each normal capture. cnt_stall increments each stall-only cycle. cnt_flush increments each redirect cycle. Counters saturate at all-ones and never wrap. Counters hold during reset_b=0 and clear at that edge.
- Undefined: counter logic is not generated; cnt_* ports remain and are tied to 0.

Decomposition:
- Shared package pipeline_pkg holds:
  - XLEN.
  - NOP_INSTR = 32'h00000013.
  - if_id_t packed struct {pc, instr, valid}, reused by the ID stage.
  - PC_INC = 4.
- One sub-module, if_perf_counter: a saturating CNT_W counter with inc and sync clear, instantiated three times under IF_PERF_CNT_EN.

Test Plan:
- Reset release, imem returns addr-indexed words, no stall: imem_addr steps 0,4,8,12. if_id_pc lags one cycle: 0,4,8 with valid=1. With macro, cnt_fetch=3 after 3 captures.
- stall held 2 cycles at pc_q=8: imem_addr stays 8 and if_id_pc stays 4 for 2 cycles, then resumes 8,12. With macro, cnt_stall=2.
- redirect_en=1, redirect_pc=0x40 while stall=1: next cycle pc_q=0x40, if_id_valid=0, if_id_instr=0x00000013. Following cycle if_id_pc=0x40, valid=1. With macro, cnt_flush=1.
- redirect_pc=0x46: pc_q=0x44 and fetch_misalign=1. It stays 1 across later normal cycles and clears only on reset.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFF8, run 3 cycles: imem_addr goes ...FFF8, ...FFFC, 0 with no error.
- reset_b dropped for 1 cycle mid-stream at pc_q=0x20: next cycle pc_q=RESET_PC, if_id_valid=0, counters=0.
